// File: rtl/if_inst_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, inst} entries,
// up to two pushes and two pops per cycle, head/head+1 exposed combinationally.
module if_inst_queue #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             inst_ok,
  input  logic             inst_ok_1,
  input  logic             inst_ok_2,
  input  logic [31:0]      inst_data_1,
  input  logic [31:0]      inst_data_2,
  input  logic [31:0]      inst_pc,
  input  logic [1:0]       pop_num,
  output logic             out_valid_1,
  output logic             out_valid_2,
  output logic [31:0]      out_inst_1,
  output logic [31:0]      out_inst_2,
  output logic [31:0]      out_pc_1,
  output logic [31:0]      out_pc_2,
  output logic             queue_full,
  output logic [PTR_W:0]   queue_count
);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [1:0]       push_n, pop_req, pop_eff;
  logic [31:0]      pc_slot2;
  logic [DEPTH-1:0][63:0] entry;

  assign head_p1  = head_q + PTR_W'(1);
  assign tail_p1  = tail_q + PTR_W'(1);
  assign pc_slot2 = inst_pc + 32'd4;

  assign queue_full = (count_q > (PTR_W+1)'(DEPTH - 2));

  // Slot 2 only ever rides along with slot 1; a lone slot-2 response is ignored.
  assign push_n = (flush || queue_full || !inst_ok || !inst_ok_1) ? 2'd0
                : (inst_ok_2 ? 2'd2 : 2'd1);

  // Pops see only the occupancy before this edge, never same-cycle pushes.
  assign pop_req = (pop_num == 2'd3) ? 2'd2 : pop_num;
  assign pop_eff = (count_q < (PTR_W+1)'(pop_req)) ? count_q[1:0] : pop_req;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_eff);
      tail_d  = tail_q + PTR_W'(push_n);
      count_d = count_q + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_eff);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic        wr1, wr2;
    logic [31:0] pc_q, inst_q;

    assign wr1 = (push_n != 2'd0) && (tail_q  == PTR_W'(gi));
    assign wr2 = (push_n == 2'd2) && (tail_p1 == PTR_W'(gi));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pc_q   <= '0;
        inst_q <= '0;
      end else if (wr1) begin
        pc_q   <= inst_pc;
        inst_q <= inst_data_1;
      end else if (wr2) begin
        pc_q   <= pc_slot2;
        inst_q <= inst_data_2;
      end
    end

    assign entry[gi] = {pc_q, inst_q};
  end

  assign out_pc_1    = entry[head_q][63:32];
  assign out_inst_1  = entry[head_q][31:0];
  assign out_pc_2    = entry[head_p1][63:32];
  assign out_inst_2  = entry[head_p1][31:0];
  assign out_valid_1 = (count_q >= (PTR_W+1)'(1));
  assign out_valid_2 = (count_q >= (PTR_W+1)'(2));
  assign queue_count = count_q;

endmodule
